// File: rtl/csr_mmio_router.sv
// Routes the AFU MMIO request channel to NUM_SUB sub-CSR windows and merges their read responses
// back round-robin. Define SOFF_CSR_ROUTER_STATS_EN to add the 4x32-bit stats output.
module csr_mmio_router #(
   parameter int          NUM_SUB    = 4,
   parameter logic [15:0] BASE_ADDR  = 16'h0040,
   parameter int          WIN_BITS   = 10,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [15:0]           afu_rx_addr,
   input  logic [8:0]            afu_rx_tid,
   input  logic [63:0]           afu_rx_data,
   input  logic                  afu_rx_rd_valid,
   input  logic                  afu_rx_wr_valid,
   output logic [8:0]            afu_tx_tid,
   output logic [63:0]           afu_tx_data,
   output logic                  afu_tx_rd_valid,
   output logic [15:0]           sub_rx_addr,
   output logic [8:0]            sub_rx_tid,
   output logic [63:0]           sub_rx_data,
   output logic [NUM_SUB-1:0]    sub_rx_rd_valid,
   output logic [NUM_SUB-1:0]    sub_rx_wr_valid,
   input  logic [NUM_SUB*9-1:0]  sub_tx_tid,
   input  logic [NUM_SUB*64-1:0] sub_tx_data,
   input  logic [NUM_SUB-1:0]    sub_tx_rd_valid,
`ifdef SOFF_CSR_ROUTER_STATS_EN
   output logic [127:0]          stats,
`endif
   output logic                  rsp_ovf
);

   localparam int NREQ = NUM_SUB + 1;
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int RW   = $clog2(NREQ);
   localparam int EW   = 73;

   logic [15:0]        off_s;
   logic [15:0]        win_s;
   logic               hit_s;
   logic [NUM_SUB-1:0] sel_s;

   logic               miss_rd_r;
   logic [8:0]         miss_tid_r;

   logic [NREQ-1:0]    push_s;
   logic [EW-1:0]      push_entry_s [NREQ];
   logic [NREQ-1:0]    empty_s;
   logic [NREQ-1:0]    full_s;
   logic [NREQ-1:0]    pop_s;
   logic [NREQ-1:0]    accept_s;
   logic [NREQ-1:0]    drop_s;

   logic [EW-1:0]      fifo_mem_r [NREQ][FIFO_DEPTH];
   logic [PW:0]        wr_ptr_r [NREQ];
   logic [PW:0]        rd_ptr_r [NREQ];

   logic [RW-1:0]      rr_ptr_r;
   logic               grant_valid_s;
   logic [RW-1:0]      grant_idx_s;
   logic [EW-1:0]      head_s;

   // Window decode of the incoming request address.
   always_comb begin
      off_s = afu_rx_addr - BASE_ADDR;
      win_s = off_s >> WIN_BITS;
      hit_s = (afu_rx_addr >= BASE_ADDR) && (win_s < 16'(NUM_SUB));
      sel_s = {NUM_SUB{1'b0}};
      for (int i = 0; i < NUM_SUB; i++) begin
         if (hit_s && (win_s == 16'(i))) begin
            sel_s[i] = 1'b1;
         end else begin
            sel_s[i] = 1'b0;
         end
      end
   end

   // Request register: header/data broadcast, valids steered to the decoded sub only.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sub_rx_addr     <= 16'h0000;
         sub_rx_tid      <= 9'h000;
         sub_rx_data     <= 64'h0;
         sub_rx_rd_valid <= {NUM_SUB{1'b0}};
         sub_rx_wr_valid <= {NUM_SUB{1'b0}};
         miss_rd_r       <= 1'b0;
         miss_tid_r      <= 9'h000;
      end else begin
         sub_rx_addr     <= afu_rx_addr;
         sub_rx_tid      <= afu_rx_tid;
         sub_rx_data     <= afu_rx_data;
         sub_rx_rd_valid <= sel_s & {NUM_SUB{afu_rx_rd_valid}};
         sub_rx_wr_valid <= sel_s & {NUM_SUB{afu_rx_wr_valid}};
         miss_rd_r       <= afu_rx_rd_valid && !hit_s;
         miss_tid_r      <= afu_rx_tid;
      end
   end

   // Push sources: one per sub, plus the synthesized all-ones miss response as the last requester.
   always_comb begin
      push_s = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         push_entry_s[i] = {EW{1'b0}};
      end
      for (int i = 0; i < NUM_SUB; i++) begin
         push_s[i]       = sub_tx_rd_valid[i];
         push_entry_s[i] = {sub_tx_tid[i*9 +: 9], sub_tx_data[i*64 +: 64]};
      end
      push_s[NUM_SUB]       = miss_rd_r;
      push_entry_s[NUM_SUB] = {miss_tid_r, 64'hFFFF_FFFF_FFFF_FFFF};
   end

   // FIFO occupancy from pointers; the extra wrap bit separates full from empty.
   always_comb begin
      empty_s = {NREQ{1'b0}};
      full_s  = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         empty_s[i] = (wr_ptr_r[i] == rd_ptr_r[i]);
         full_s[i]  = (wr_ptr_r[i][PW] != rd_ptr_r[i][PW]) &&
                      (wr_ptr_r[i][PW-1:0] == rd_ptr_r[i][PW-1:0]);
      end
   end

   // Round-robin search over non-empty FIFOs starting at the pointer.
   always_comb begin
      logic [RW:0] cand;
      grant_valid_s = 1'b0;
      grant_idx_s   = {RW{1'b0}};
      cand          = {(RW+1){1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr_r} + (RW+1)'(k);
         if (cand >= (RW+1)'(NREQ)) begin
            cand = cand - (RW+1)'(NREQ);
         end else begin
            cand = cand;
         end
         if (!grant_valid_s && !empty_s[cand[RW-1:0]]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = cand[RW-1:0];
         end else begin
            grant_valid_s = grant_valid_s;
         end
      end
   end

   // A pop frees the slot in the same cycle, so push-on-full with pop is not an overflow.
   always_comb begin
      pop_s    = {NREQ{1'b0}};
      accept_s = {NREQ{1'b0}};
      drop_s   = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         pop_s[i]    = grant_valid_s && (grant_idx_s == RW'(i));
         accept_s[i] = push_s[i] && (!full_s[i] || pop_s[i]);
         drop_s[i]   = push_s[i] && full_s[i] && !pop_s[i];
      end
   end

   assign head_s = fifo_mem_r[grant_idx_s][rd_ptr_r[grant_idx_s][PW-1:0]];

   // Response storage; pointers alone define occupancy, so the array needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (accept_s[i]) begin
            fifo_mem_r[i][wr_ptr_r[i][PW-1:0]] <= push_entry_s[i];
         end
      end
   end

   // FIFO pointer update.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NREQ; i++) begin
            wr_ptr_r[i] <= {(PW+1){1'b0}};
            rd_ptr_r[i] <= {(PW+1){1'b0}};
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (accept_s[i]) begin
               wr_ptr_r[i] <= wr_ptr_r[i] + (PW+1)'(1);
            end
            if (pop_s[i]) begin
               rd_ptr_r[i] <= rd_ptr_r[i] + (PW+1)'(1);
            end
         end
      end
   end

   // Round-robin pointer and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_ptr_r <= {RW{1'b0}};
         rsp_ovf  <= 1'b0;
      end else begin
         if (grant_valid_s) begin
            if (grant_idx_s == RW'(NUM_SUB)) begin
               rr_ptr_r <= {RW{1'b0}};
            end else begin
               rr_ptr_r <= grant_idx_s + RW'(1);
            end
         end
         rsp_ovf <= rsp_ovf | (|drop_s);
      end
   end

   // Merged response output register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         afu_tx_rd_valid <= 1'b0;
         afu_tx_tid      <= 9'h000;
         afu_tx_data     <= 64'h0;
      end else begin
         afu_tx_rd_valid <= grant_valid_s;
         if (grant_valid_s) begin
            afu_tx_tid  <= head_s[72:64];
            afu_tx_data <= head_s[63:0];
         end
      end
   end

`ifdef SOFF_CSR_ROUTER_STATS_EN
   function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] n);
      logic [32:0] sum;
      sum = {1'b0, v} + {1'b0, n};
      if (sum[32]) begin
         sat_add = 32'hFFFF_FFFF;
      end else begin
         sat_add = sum[31:0];
      end
   endfunction

   logic [31:0] rd_cnt_r;
   logic [31:0] wr_cnt_r;
   logic [31:0] miss_cnt_r;
   logic [31:0] drop_cnt_r;
   logic [31:0] drop_num_s;

   // Several FIFOs can drop in the same cycle.
   always_comb begin
      drop_num_s = 32'd0;
      for (int i = 0; i < NREQ; i++) begin
         drop_num_s = drop_num_s + {31'd0, drop_s[i]};
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_cnt_r   <= 32'd0;
         wr_cnt_r   <= 32'd0;
         miss_cnt_r <= 32'd0;
         drop_cnt_r <= 32'd0;
      end else begin
         rd_cnt_r   <= sat_add(rd_cnt_r, {31'd0, afu_rx_rd_valid});
         wr_cnt_r   <= sat_add(wr_cnt_r, {31'd0, afu_rx_wr_valid});
         miss_cnt_r <= sat_add(miss_cnt_r, {31'd0, (afu_rx_rd_valid | afu_rx_wr_valid) & ~hit_s});
         drop_cnt_r <= sat_add(drop_cnt_r, drop_num_s);
      end
   end

   assign stats = {rd_cnt_r, wr_cnt_r, miss_cnt_r, drop_cnt_r};
`endif

endmodule
